// File: rtl/booth_mult_seq.sv
// booth_mult_seq -- sequential radix-2 Booth multiplier.
//
// The unit takes W-bit operands A and B as either two's complement or
// unsigned values, chosen by tc. It retires one Booth iteration per clock
// and finishes in W+1 iterations. The 2*W-bit product in P is held until
// the next operation completes.
//
// Compile-time option:
//   BOOTH_MULT_ACC_EN  When defined, completion adds the product into P
//                      (multiply-accumulate). acc_clr then clears P.
//                      When undefined, acc_clr is ignored.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   load     start request; accepted only in IDLE or DONE
//   tc       1 = two's complement operands, 0 = unsigned; sampled with load
//   A        multiplicand; sampled with load
//   B        multiplier; sampled with load
//   acc_clr  clears the accumulator (MAC build only)
//   P        product, or accumulator in the MAC build
//   busy     high while iterating
//   done     one-cycle pulse when P holds a new result
module booth_mult_seq #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tc,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             acc_clr,
    output logic [2*W-1:0]   P,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic signed [W:0] acc;
    logic signed [W:0] m;
    logic [W:0]        q;
    logic              q_m1;
    logic [CNT_W-1:0]  cnt;

    logic signed [W:0] acc_nxt;
    logic [W:0]        q_nxt;
    logic              q_m1_nxt;
    logic [2*W-1:0]    result;
    logic [2*W-1:0]    p_done;
    logic              clr_en;
    logic              last;

    // Widen an operand to W+1 bits so that unsigned values keep a zero sign
    // bit and the Booth recoding stays exact in both modes.
    function automatic logic [W:0] extend(input logic [W-1:0] v, input logic s);
        return {s & v[W-1], v};
    endfunction

    // One Booth iteration: add/subtract M based on {Q0, q_-1}, then
    // arithmetic-shift the whole {Acc, Q, q_-1} right by one.
    // Returned as {acc', q', q_-1'}.
    function automatic logic [2*W+2:0] booth_step(
        input logic signed [W:0] a,
        input logic [W:0]        qv,
        input logic              qm,
        input logic signed [W:0] mv
    );
        logic signed [W:0] sum;
        case ({qv[0], qm})
            2'b01:   sum = a + mv;
            2'b10:   sum = a - mv;
            default: sum = a;
        endcase
        // The shift is folded into the concatenation: the duplicated sign
        // bit enters at the top, and qv[0] falls into the q_-1 position.
        return {sum[W], sum, qv};
    endfunction

    assign {acc_nxt, q_nxt, q_m1_nxt} = booth_step(acc, q, q_m1, m);

    // Low 2*W bits of {Acc, Q} after the final shift.
    assign result = {acc_nxt[W-2:0], q_nxt};
    assign last   = (cnt == CNT_W'(W));

`ifdef BOOTH_MULT_ACC_EN
    // A clear on the completion edge wins first; the new product then lands
    // in a zeroed accumulator.
    assign p_done = (acc_clr ? '0 : P) + result;
    assign clr_en = acc_clr;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign p_done         = result;
    assign clr_en         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (clr_en)
                        P <= '0;
                    if (load) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        m     <= extend(A, tc);
                        q     <= extend(B, tc);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // load is ignored here; the captured operands run to completion.
                    acc  <= acc_nxt;
                    q    <= q_nxt;
                    q_m1 <= q_m1_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        P     <= p_done;
                    end else if (clr_en) begin
                        P <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
